// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word width, fetch FSM states and the
// instruction-buffer entry layout.
package cpu_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {instr, pc} pairs between fetch and decode.
// A full FIFO still accepts a push when a pop happens on the same edge.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WORD_W-1:0]            push_instr,
  input  logic [WORD_W-1:0]            push_pc,
  input  logic                         pop,
  output logic                         head_valid,
  output logic [WORD_W-1:0]            head_instr,
  output logic [WORD_W-1:0]            head_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL) || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{instr: push_instr, pc: push_pc};
  end

  // Empty FIFO presents zeros so decode never sees stale storage.
  assign head_valid = (count != '0);
  assign head_instr = head_valid ? mem[rd_ptr].instr : '0;
  assign head_pc    = head_valid ? mem[rd_ptr].pc    : '0;

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: PC register, single-outstanding memory request FSM,
// wrong-path response dropping on redirect, and the buffer toward decode.
module fetch_pc_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] next_pc,
  input  logic              flush,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [WORD_W-1:0] id_instr,
  output logic [WORD_W-1:0] id_pc
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic              drop;
  logic              drop_next;
  logic [WORD_W-1:0] pc_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic              take;
  logic              pop;

  assign pc_plus4  = pc + PC_STEP;
  assign imem_addr = pc;
  assign imem_req  = (state == S_REQ) && !drop;

  assign take = (state == S_REQ) && imem_ack && !drop && !flush;
  assign pop  = id_valid && id_ready && !flush;

  always_comb begin
    count_after = count;
    if (take) count_after = count_after + CNT_W'(1);
    if (pop)  count_after = count_after - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      drop  <= 1'b0;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      drop  <= drop_next;
      pc    <= pc_next;
    end
  end

  // A redirect while a request is still in flight must swallow that request's
  // eventual response before issuing a new one.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    pc_next    = pc;
    if (flush) begin
      state_next = S_REQ;
      pc_next    = next_pc;
      drop_next  = (state == S_REQ) && !imem_ack;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != FULL) state_next = S_REQ;
        end
        S_REQ: begin
          if (imem_ack) begin
            if (drop) begin
              drop_next = 1'b0;
            end else begin
              pc_next    = next_pc;
              state_next = (count_after != FULL) ? S_REQ : S_IDLE;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (take),
    .push_instr(imem_rdata),
    .push_pc   (pc),
    .pop       (pop),
    .head_valid(id_valid),
    .head_instr(id_instr),
    .head_pc   (id_pc),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage: directed sequences, a redirect table,
// and a randomized run scored against an in-order PC stream model.
module tb_fetch_pc_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        flush;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  logic [31:0] flush_target;
  int          checks;
  int          errors;

  // Memory model: zero-wait when mem_delay==0, else one request latched and
  // answered mem_delay cycles later.
  int          mem_delay;
  logic        mem_clear;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr_l;
  logic        stray_ack;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign next_pc    = flush ? flush_target : pc_plus4;
  assign imem_ack   = stray_ack || ((mem_delay == 0) ? imem_req : (mem_busy && mem_cnt == 0));
  assign imem_rdata = (mem_delay == 0) ? instr_of(imem_addr) : instr_of(mem_addr_l);

  always @(posedge clk) begin
    if (mem_clear) begin
      mem_busy <= 1'b0;
      mem_cnt  <= 0;
    end else if (mem_delay > 0) begin
      if (mem_busy) begin
        if (mem_cnt == 0) mem_busy <= 1'b0;
        else              mem_cnt  <= mem_cnt - 1;
      end else if (imem_req) begin
        mem_busy   <= 1'b1;
        mem_cnt    <= mem_delay - 1;
        mem_addr_l <= imem_addr;
      end
    end
  end

  fetch_pc_stage #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next_pc   (next_pc),
    .flush     (flush),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_instr  (id_instr),
    .id_pc     (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [31:0] target;
    logic        ready;
    logic [31:0] exp_plus4;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic fl, input logic [31:0] tgt);
    id_ready     = rdy;
    flush        = fl;
    flush_target = tgt;
    step();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    flush     = 1'b0;
    stray_ack = 1'b0;
    mem_clear = 1'b1;
    step();
    step();
    mem_clear = 1'b0;
  endtask

  initial begin
    logic        found;
    logic [31:0] exp_pc;
    logic [31:0] sum;
    int          accepted;

    checks       = 0;
    errors       = 0;
    id_ready     = 1'b1;
    flush_target = 32'h0;
    mem_delay    = 0;
    mem_addr_l   = 32'h0;

    vecs[0] = '{target: 32'h0000_0100, ready: 1'b1, exp_plus4: 32'h0000_0104};
    vecs[1] = '{target: 32'hFFFF_FFFC, ready: 1'b0, exp_plus4: 32'h0000_0000};
    vecs[2] = '{target: 32'h8000_0000, ready: 1'b1, exp_plus4: 32'h8000_0004};
    vecs[3] = '{target: 32'h7FFF_FFFC, ready: 1'b0, exp_plus4: 32'h8000_0000};
    vecs[4] = '{target: 32'hFFFF_FFF8, ready: 1'b1, exp_plus4: 32'hFFFF_FFFC};

    // Reset values and streaming fetch with zero-wait memory.
    doReset();
    step();
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
    checkOutput("rst_id_instr", id_instr, 32'h0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_pc_plus4", pc_plus4, 32'h4);
    rst_n = 1'b1;
    step();
    checkOutput("s1_req", 32'(imem_req), 32'd1);
    checkOutput("s1_valid_early", 32'(id_valid), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      checkOutput("s1_valid", 32'(id_valid), 32'd1);
      checkOutput("s1_id_pc", id_pc, 32'(4 * k));
      checkOutput("s1_id_instr", id_instr, instr_of(32'(4 * k)));
      step();
    end

    // Backpressure: two words buffered, fetch stalls, then drains in order.
    doReset();
    id_ready = 1'b0;
    rst_n    = 1'b1;
    step();
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_valid", 32'(id_valid), 32'd1);
      checkOutput("bp_id_pc", id_pc, 32'h0);
      checkOutput("bp_id_instr", id_instr, instr_of(32'h0));
      checkOutput("bp_req_low", 32'(imem_req), 32'd0);
      step();
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("bp_drain1_pc", id_pc, 32'h4);
    checkOutput("bp_drain1_valid", 32'(id_valid), 32'd1);
    step();
    checkOutput("bp_resume_req", 32'(imem_req), 32'd1);
    checkOutput("bp_resume_addr", imem_addr, 32'h8);
    checkOutput("bp_empty", 32'(id_valid), 32'd0);
    step();
    checkOutput("bp_next_pc", id_pc, 32'h8);

    // Slow memory: address held for all request cycles, one push per response.
    doReset();
    mem_delay = 3;
    rst_n     = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 32'h8) found = 1'b1;
    end
    checkOutput("slow_found_req8", 32'(found), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("slow_req", 32'(imem_req), 32'd1);
      checkOutput("slow_addr", imem_addr, 32'h8);
      checkOutput("slow_ack", 32'(imem_ack), 32'(i == 3));
      step();
    end
    checkOutput("slow_push_pc", id_pc, 32'h8);
    checkOutput("slow_push_valid", 32'(id_valid), 32'd1);
    step();
    checkOutput("slow_single_push", 32'(id_valid), 32'd0);

    // Redirect while a request is in flight: stale response is dropped.
    doReset();
    mem_delay = 3;
    rst_n     = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 32'h10) found = 1'b1;
    end
    checkOutput("fl_found_req10", 32'(found), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h100);
    flush = 1'b0;
    checkOutput("fl_pc", pc, 32'h100);
    checkOutput("fl_fifo_empty", 32'(id_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      checkOutput("fl_req_held_low", 32'(imem_req), 32'd0);
      if (imem_ack) found = 1'b1;
      step();
    end
    checkOutput("fl_stale_ack_seen", 32'(found), 32'd1);
    checkOutput("fl_stale_not_pushed", 32'(id_valid), 32'd0);
    checkOutput("fl_new_req", 32'(imem_req), 32'd1);
    checkOutput("fl_new_addr", imem_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (id_valid) found = 1'b1;
    end
    checkOutput("fl_first_valid", 32'(found), 32'd1);
    checkOutput("fl_first_id_pc", id_pc, 32'h100);
    checkOutput("fl_first_instr", id_instr, instr_of(32'h100));

    // Redirect table: flush to each target, with or without a full FIFO.
    doReset();
    mem_delay = 0;
    rst_n     = 1'b1;
    step();
    step();
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].ready, 1'b0, 32'h0);
      applyStimulus(vecs[v].ready, 1'b0, 32'h0);
      applyStimulus(vecs[v].ready, 1'b0, 32'h0);
      applyStimulus(vecs[v].ready, 1'b1, vecs[v].target);
      flush = 1'b0;
      checkOutput("tab_empty", 32'(id_valid), 32'd0);
      checkOutput("tab_pc", pc, vecs[v].target);
      checkOutput("tab_pc_plus4", pc_plus4, vecs[v].exp_plus4);
      checkOutput("tab_req", 32'(imem_req), 32'd1);
      checkOutput("tab_addr", imem_addr, vecs[v].target);
      step();
      checkOutput("tab_id_pc", id_pc, vecs[v].target);
      checkOutput("tab_id_instr", id_instr, instr_of(vecs[v].target));
      checkOutput("tab_next_addr", imem_addr, vecs[v].exp_plus4);
    end

    // Reset in the middle of a request with buffered data; stray ack in idle.
    doReset();
    mem_delay = 3;
    id_ready  = 1'b0;
    rst_n     = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (id_valid) found = 1'b1;
    end
    checkOutput("mr_buffered", 32'(found), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    checkOutput("mr_valid", 32'(id_valid), 32'd0);
    checkOutput("mr_pc", pc, 32'h0);
    checkOutput("mr_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 4; i++) step();
    mem_delay = 0;
    stray_ack = 1'b1;
    rst_n     = 1'b1;
    step();
    stray_ack = 1'b0;
    checkOutput("mr_stray_pc", pc, 32'h0);
    checkOutput("mr_stray_valid", 32'(id_valid), 32'd0);
    checkOutput("mr_stray_req", 32'(imem_req), 32'd1);

    // Randomized run: accepted words must follow the redirected PC stream.
    doReset();
    mem_delay = 0;
    rst_n     = 1'b1;
    exp_pc    = 32'h0;
    accepted  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((cyc % 200) == 0 && !mem_busy) mem_delay = $urandom_range(0, 3);
      id_ready     = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 29) == 0);
      flush_target = $urandom & 32'hFFFF_FFFC;
      sum = pc + 32'd4;
      checkOutput("rnd_pc_plus4", pc_plus4, sum);
      if (imem_req) checkOutput("rnd_addr_is_pc", imem_addr, pc);
      if (imem_req && mem_delay > 0 && mem_busy)
        checkOutput("rnd_single_outstanding", imem_addr, mem_addr_l);
      if (flush) begin
        exp_pc = flush_target;
      end else if (id_valid && id_ready) begin
        checkOutput("rnd_id_pc", id_pc, exp_pc);
        checkOutput("rnd_id_instr", id_instr, instr_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      step();
    end
    flush = 1'b0;
    checkOutput("rnd_progress", 32'(accepted > 100), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
